// File: rtl/x_mux_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : x_mux_trigger_ctrl
// Brief    : Sequencer for the mux-based trigger delay line. It presents a
//            pattern, waits for it to settle, then fires trigger pulses with
//            recovery gaps. Optional abort is enabled by the macro
//            X_MUX_TRIGGER_CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module x_mux_trigger_ctrl #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 8,
    parameter int SETTLE_CYC  = 2,
    parameter int RECOVER_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DATA_W-1:0] i_cmd_data,
    input  logic [CNT_W-1:0]  i_cmd_hold,
    input  logic [CNT_W-1:0]  i_cmd_repeat,
`ifdef X_MUX_TRIGGER_CTRL_ABORT_EN
    input  logic              i_abort,
    output logic              o_aborted,
`endif
    output logic [DATA_W-1:0] o_data,
    output logic              o_trigger,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_fire_count
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int REC_W = $clog2(RECOVER_CYC + 1);
    localparam int AUX_W = (SET_W > REC_W) ? SET_W : REC_W;
    localparam int TMR_W = (CNT_W > AUX_W) ? CNT_W : AUX_W;

    localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] RECOVER_LOAD = TMR_W'(RECOVER_CYC - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_FIRE    = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [TMR_W-1:0]  tmr_q,      tmr_d;
    logic [CNT_W-1:0]  hold_q,     hold_d;
    logic [CNT_W-1:0]  rep_q,      rep_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              trig_q,     trig_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              ready_q,    ready_d;
    logic [15:0]       fire_cnt_q, fire_cnt_d;

    logic              w_abort;
    logic [TMR_W-1:0]  w_hold_load;

    // Timer counts down to zero, so a hold of 0 behaves like a hold of 1.
    assign w_hold_load = (hold_q == '0) ? '0 : TMR_W'(hold_q - CNT_W'(1));

`ifdef X_MUX_TRIGGER_CTRL_ABORT_EN
    logic abort_pend_q, abort_pend_d;
    logic aborted_q,    aborted_d;

    assign w_abort = i_abort && (state_q != ST_IDLE);

    always_comb begin
        abort_pend_d = abort_pend_q;
        if (state_q == ST_IDLE) begin
            abort_pend_d = 1'b0;
        end else if (w_abort) begin
            abort_pend_d = 1'b1;
        end
        aborted_d = done_d && (abort_pend_q || w_abort);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            abort_pend_q <= abort_pend_d;
            aborted_q    <= aborted_d;
        end
    end

    assign o_aborted = aborted_q;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        hold_d     = hold_q;
        rep_d      = rep_q;
        data_d     = data_q;
        trig_d     = trig_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ready_d    = ready_q;
        fire_cnt_d = fire_cnt_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (i_cmd_valid && ready_q) begin
                    hold_d  = i_cmd_hold;
                    rep_d   = i_cmd_repeat;
                    data_d  = i_cmd_data;
                    tmr_d   = SETTLE_LOAD;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_abort) begin
                    rep_d   = '0;
                    tmr_d   = RECOVER_LOAD;
                    state_d = ST_RECOVER;
                end else if (tmr_q == '0) begin
                    tmr_d      = w_hold_load;
                    trig_d     = 1'b1;
                    fire_cnt_d = fire_cnt_q + 16'd1;
                    state_d    = ST_FIRE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_FIRE: begin
                if (w_abort || tmr_q == '0) begin
                    if (w_abort) begin
                        rep_d = '0;
                    end
                    tmr_d   = RECOVER_LOAD;
                    trig_d  = 1'b0;
                    state_d = ST_RECOVER;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_RECOVER: begin
                if (w_abort) begin
                    rep_d = '0;
                end
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (rep_q != '0 && !w_abort) begin
                    // Repeats re-fire without re-settling; the pattern is already stable.
                    rep_d      = rep_q - CNT_W'(1);
                    tmr_d      = w_hold_load;
                    trig_d     = 1'b1;
                    fire_cnt_d = fire_cnt_q + 16'd1;
                    state_d    = ST_FIRE;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            hold_q     <= '0;
            rep_q      <= '0;
            data_q     <= '0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            fire_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            hold_q     <= hold_d;
            rep_q      <= rep_d;
            data_q     <= data_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            fire_cnt_q <= fire_cnt_d;
        end
    end

    assign o_cmd_ready  = ready_q;
    assign o_data       = data_q;
    assign o_trigger    = trig_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_fire_count = fire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_x_mux_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_mux_trigger_ctrl
// Brief    : Directed self-checking bench for x_mux_trigger_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_mux_trigger_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic [7:0]  cmd_hold;
    logic [7:0]  cmd_repeat;
    logic [31:0] data;
    logic        trigger;
    logic        busy;
    logic        done;
    logic [15:0] fire_count;
`ifdef X_MUX_TRIGGER_CTRL_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    int total = 0;
    int bad   = 0;
    int exp_fires = 0;

    x_mux_trigger_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_data   (cmd_data),
        .i_cmd_hold   (cmd_hold),
        .i_cmd_repeat (cmd_repeat),
`ifdef X_MUX_TRIGGER_CTRL_ABORT_EN
        .i_abort      (abort),
        .o_aborted    (aborted),
`endif
        .o_data       (data),
        .o_trigger    (trigger),
        .o_busy       (busy),
        .o_done       (done),
        .o_fire_count (fire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: present a command so the next posedge accepts it.
    task automatic drive_cmd(input logic [31:0] d, input logic [7:0] h, input logic [7:0] r);
        cmd_valid  = 1'b1;
        cmd_data   = d;
        cmd_hold   = h;
        cmd_repeat = r;
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (trigger !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1
            || data !== 32'h0 || fire_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_values: trig=%b busy=%b done=%b ready=%b data=%h cnt=%h, want 0 0 0 1 0 0",
                     trigger, busy, done, cmd_ready, data, fire_count);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_single;
        drive_cmd(32'hA5A5_0F0F, 8'd3, 8'd0);
        exp_fires += 1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            total++;
            if (data !== 32'hA5A5_0F0F) begin
                bad++;
                $display("FAIL single_data j=%0d: got %h want a5a50f0f", j, data);
            end
            total++;
            if (trigger !== (j >= 3 && j <= 5)) begin
                bad++;
                $display("FAIL single_trig j=%0d: got %b want %b", j, trigger, (j >= 3 && j <= 5));
            end
            total++;
            if (done !== (j == 10) || cmd_ready !== (j >= 10) || busy !== (j <= 9)) begin
                bad++;
                $display("FAIL single_ctl j=%0d: done=%b ready=%b busy=%b want %b %b %b",
                         j, done, cmd_ready, busy, (j == 10), (j >= 10), (j <= 9));
            end
        end
        total++;
        if (fire_count !== 16'(exp_fires)) begin
            bad++;
            $display("FAIL single_count: got %0d want %0d", fire_count, exp_fires);
        end
    endtask

    task automatic test_repeat;
        int busy_cyc = 0;
        int done_cnt = 0;
        drive_cmd(32'h0000_1234, 8'd0, 8'd2);
        exp_fires += 3;
        for (int j = 1; j <= 22; j++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            total++;
            if (trigger !== (j == 3 || j == 8 || j == 13)) begin
                bad++;
                $display("FAIL repeat_trig j=%0d: got %b want %b", j, trigger, (j == 3 || j == 8 || j == 13));
            end
            if (j == 18) begin
                total++;
                if (done !== 1'b1 || cmd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL repeat_done: done=%b ready=%b want 1 1", done, cmd_ready);
                end
            end
        end
        total++;
        if (busy_cyc != 17 || done_cnt != 1) begin
            bad++;
            $display("FAIL repeat_busy: busy=%0d done=%0d want 17 1", busy_cyc, done_cnt);
        end
        total++;
        if (fire_count !== 16'(exp_fires)) begin
            bad++;
            $display("FAIL repeat_count: got %0d want %0d", fire_count, exp_fires);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d;
        drive_cmd(32'h1111_2222, 8'd1, 8'd0);
        exp_fires += 2;
        for (int j = 1; j <= 19; j++) begin
            @(negedge clk);
            exp_d = (j <= 8) ? 32'h1111_2222 : 32'h3333_4444;
            total++;
            if (data !== exp_d) begin
                bad++;
                $display("FAIL b2b_data j=%0d: got %h want %h", j, data, exp_d);
            end
            total++;
            if (trigger !== (j == 3 || j == 11 || j == 12)) begin
                bad++;
                $display("FAIL b2b_trig j=%0d: got %b want %b", j, trigger, (j == 3 || j == 11 || j == 12));
            end
            total++;
            if (done !== (j == 8 || j == 17) || busy !== (j <= 7 || (j >= 9 && j <= 16))) begin
                bad++;
                $display("FAIL b2b_ctl j=%0d: done=%b busy=%b", j, done, busy);
            end
            if (j == 1) begin
                cmd_data = 32'h3333_4444;
                cmd_hold = 8'd2;
            end
            if (j == 9) cmd_valid = 1'b0;
        end
        total++;
        if (fire_count !== 16'(exp_fires)) begin
            bad++;
            $display("FAIL b2b_count: got %0d want %0d", fire_count, exp_fires);
        end
    endtask

`ifdef X_MUX_TRIGGER_CTRL_ABORT_EN
    task automatic test_abort;
        drive_cmd(32'hCAFE_0001, 8'd3, 8'd5);
        exp_fires += 1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            total++;
            if (trigger !== (j == 3 || j == 4)) begin
                bad++;
                $display("FAIL abort_trig j=%0d: got %b want %b", j, trigger, (j == 3 || j == 4));
            end
            total++;
            if (done !== (j == 9) || aborted !== (j == 9) || busy !== (j <= 8)) begin
                bad++;
                $display("FAIL abort_ctl j=%0d: done=%b aborted=%b busy=%b", j, done, aborted, busy);
            end
            abort = (j == 4);
        end
        total++;
        if (fire_count !== 16'(exp_fires)) begin
            bad++;
            $display("FAIL abort_count: got %0d want %0d", fire_count, exp_fires);
        end
    endtask
`endif

    task automatic test_reset_mid_fire;
        drive_cmd(32'hDEAD_BEEF, 8'd5, 8'd1);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if (trigger !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre: trig=%b want 1", trigger);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (trigger !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1
            || data !== 32'h0 || fire_count !== 16'h0) begin
            bad++;
            $display("FAIL midrst_async: trig=%b busy=%b done=%b ready=%b data=%h cnt=%h",
                     trigger, busy, done, cmd_ready, data, fire_count);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_fires = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || trigger !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midrst_after j=%0d: done=%b trig=%b busy=%b want 0 0 0", j, done, trigger, busy);
            end
        end
    endtask

    task automatic test_fire_wrap;
        int guard = 0;
        force dut.fire_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.fire_cnt_q;
        @(negedge clk);
        total++;
        if (fire_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_preload: got %h want ffff", fire_count);
        end
        drive_cmd(32'h0000_00FF, 8'd1, 8'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!done && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 50) begin
            bad++;
            $display("FAIL wrap_timeout: done=%b want 1 within 50 cycles", done);
        end
        total++;
        if (fire_count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_value: got %h want 0000", fire_count);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_data   = '0;
        cmd_hold   = '0;
        cmd_repeat = '0;
`ifdef X_MUX_TRIGGER_CTRL_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        @(negedge clk);
        test_single();
        test_repeat();
        test_back_to_back();
`ifdef X_MUX_TRIGGER_CTRL_ABORT_EN
        test_abort();
`endif
        test_reset_mid_fire();
        test_fire_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
